// File: rtl/ball_mover_pkg.sv
// Shared constants, FSM encoding and the saturating step helper for the ball mover.
package ball_mover_pkg;

    localparam int X_MAX   = 160;
    localparam int Y_MAX   = 120;
    localparam int SIZE    = 4;
    localparam int STEP    = 1;
    localparam int X_START = 78;
    localparam int Y_START = 100;
    localparam int SCAN_W  = 4;

    localparam logic [2:0] BG_COLOUR   = 3'b000;
    localparam logic [2:0] BALL_COLOUR = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ERASE  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_DRAW   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Moves one axis by STEP in 11-bit signed arithmetic, then clamps to [0, lim-SIZE]
    // so the ball can never underflow below 0 or poke past the playfield edge.
    function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic up,
                                              input int lim);
        logic signed [10:0] w_sum;
        logic signed [10:0] w_hi;
        logic signed [10:0] w_step;
        w_step = 11'(STEP);
        w_hi   = 11'(lim - SIZE);
        w_sum  = up ? ($signed({1'b0, pos}) + w_step) : ($signed({1'b0, pos}) - w_step);
        if (w_sum < 11'sd0)
            return 10'd0;
        else if (w_sum > w_hi)
            return 10'(w_hi);
        else
            return 10'(w_sum);
    endfunction

endpackage

// File: rtl/ball_mover_square_scanner.sv
// Raster scanner over a SIZE x SIZE square: cx is the inner index, cy the outer.
module ball_mover_square_scanner
    import ball_mover_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clear,
    input  logic              i_enable,
    output logic [SCAN_W-1:0] o_cx,
    output logic [SCAN_W-1:0] o_cy,
    output logic              o_last
);

    localparam logic [SCAN_W-1:0] LAST_IDX = SCAN_W'(SIZE - 1);

    logic [SCAN_W-1:0] r_cx;
    logic [SCAN_W-1:0] r_cy;
    logic              w_row_end;

    assign w_row_end = (r_cx == LAST_IDX);
    assign o_last    = w_row_end && (r_cy == LAST_IDX);
    assign o_cx      = r_cx;
    assign o_cy      = r_cy;

    // Advance through the square in raster order, wrapping to (0,0) after the last pixel.
    always_ff @(posedge clk) begin
        if (!resetn || i_clear) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_enable) begin
            if (w_row_end) begin
                r_cx <= '0;
                r_cy <= o_last ? '0 : r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ball_mover.sv
// Per-frame ball stage: erase old square, step position, draw new square.
module ball_mover
    import ball_mover_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_tick,
    input  logic       i_x_du,
    input  logic       i_y_du,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic [9:0] o_vga_x,
    output logic [9:0] o_vga_y,
    output logic [2:0] o_vga_colour,
    output logic       o_vga_plot,
    output logic       o_busy,
    output logic       o_done
);

    state_t            r_state;
    state_t            w_next;
    logic [9:0]        r_ball_x;
    logic [9:0]        r_ball_y;
    logic [SCAN_W-1:0] w_cx;
    logic [SCAN_W-1:0] w_cy;
    logic              w_last;
    logic              w_scan_clr;
    logic              w_scan_en;
    logic              w_plot;
    logic [2:0]        w_colour;
    logic              w_busy;
    logic              w_done;

    ball_mover_square_scanner u_square_scanner (
        .clk      (clk),
        .resetn   (resetn),
        .i_clear  (w_scan_clr),
        .i_enable (w_scan_en),
        .o_cx     (w_cx),
        .o_cy     (w_cy),
        .o_last   (w_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; ticks outside IDLE are simply not looked at.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_tick) w_next = ST_ERASE;
            ST_ERASE:  if (w_last) w_next = ST_UPDATE;
            ST_UPDATE: w_next = ST_DRAW;
            ST_DRAW:   if (w_last) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Per-state control decoded from the current state; registered below.
    always_comb begin
        w_scan_en  = 1'b0;
        w_scan_clr = 1'b0;
        w_plot     = 1'b0;
        w_colour   = BG_COLOUR;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_scan_clr = 1'b1;
                w_busy     = 1'b0;
            end
            ST_ERASE: begin
                w_scan_en = 1'b1;
                w_plot    = 1'b1;
            end
            ST_UPDATE: w_scan_clr = 1'b1;
            ST_DRAW: begin
                w_scan_en = 1'b1;
                w_plot    = 1'b1;
                w_colour  = BALL_COLOUR;
            end
            ST_DONE: begin
                w_scan_clr = 1'b1;
                w_done     = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    // Ball position only moves on the single UPDATE edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ball_x <= 10'(X_START);
            r_ball_y <= 10'(Y_START);
        end else if (r_state == ST_UPDATE) begin
            r_ball_x <= step_clamp(r_ball_x, i_x_du, X_MAX);
            r_ball_y <= step_clamp(r_ball_y, i_y_du, Y_MAX);
        end
    end

    // Registered VGA port and status; coordinates hold their last value when not plotting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_vga_x      <= '0;
            o_vga_y      <= '0;
            o_vga_colour <= '0;
            o_vga_plot   <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_vga_plot <= w_plot;
            o_busy     <= w_busy;
            o_done     <= w_done;
            if (w_plot) begin
                o_vga_x      <= r_ball_x + 10'(w_cx);
                o_vga_y      <= r_ball_y + 10'(w_cy);
                o_vga_colour <= w_colour;
            end
        end
    end

    assign o_ball_x = r_ball_x;
    assign o_ball_y = r_ball_y;

endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover: vector table of frames plus edge, abort and closed-loop sequences.
module tb_ball_mover;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic       x_du = 1'b0;
    logic       y_du = 1'b0;
    logic [9:0] ball_x, ball_y, vga_x, vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    int checks = 0;
    int failures = 0;
    int mx = 78;
    int my = 100;

    typedef struct {
        logic xd;
        logic yd;
        int   ex;
        int   ey;
    } vec_t;

    vec_t vecs [5];

    ball_mover dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_tick       (tick),
        .i_x_du       (x_du),
        .i_y_du       (y_du),
        .o_ball_x     (ball_x),
        .o_ball_y     (ball_y),
        .o_vga_x      (vga_x),
        .o_vga_y      (vga_y),
        .o_vga_colour (vga_colour),
        .o_vga_plot   (vga_plot),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int step_model(input int p, input logic up, input int hi);
        if (up) return (p + 1 > hi) ? hi : p + 1;
        return (p == 0) ? 0 : p - 1;
    endfunction

    // One frame: tick sampled at edge N, then 45 observed edges. extra_tick=k re-pulses tick at edge N+k.
    task automatic run_frame(input logic xd, input logic yd, input int extra_tick);
        int ox, oy, nx, ny, nplot, ndone, done_c, bad, k, ex, ey, ec;
        ox = mx; oy = my;
        nx = step_model(mx, xd, 156);
        ny = step_model(my, yd, 116);
        nplot = 0; ndone = 0; done_c = -1; bad = 0;
        x_du = xd; y_du = yd; tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            tick = (c == extra_tick);
            @(posedge clk); #1;
            if (c == 1)  check("busy_after_tick", int'(busy), 1);
            if (c == 35) check("busy_after_done", int'(busy), 0);
            if (vga_plot) begin
                k = nplot;
                if (k < 32) begin
                    ex = ((k < 16) ? ox : nx) + (k % 16) % 4;
                    ey = ((k < 16) ? oy : ny) + (k % 16) / 4;
                    ec = (k < 16) ? 0 : 7;
                    if (int'(vga_x) != ex || int'(vga_y) != ey || int'(vga_colour) != ec) begin
                        if (bad == 0)
                            $display("FAIL plot_%0d actual=(%0d,%0d,c%0d) required=(%0d,%0d,c%0d)",
                                     k, vga_x, vga_y, vga_colour, ex, ey, ec);
                        bad++;
                    end
                end
                if (vga_x > 10'd159 || vga_y > 10'd119) bad++;
                nplot++;
            end
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
        end
        tick = 1'b0;
        check("plot_count", nplot, 32);
        check("plot_errors", bad, 0);
        check("done_count", ndone, 1);
        check("done_cycle", done_c, 34);
        check("ball_x", int'(ball_x), nx);
        check("ball_y", int'(ball_y), ny);
        mx = nx; my = ny;
    endtask

    initial begin
        int xdir, ydir;
        vecs[0] = '{1'b1, 1'b0, 79, 99};
        vecs[1] = '{1'b1, 1'b1, 80, 100};
        vecs[2] = '{1'b0, 1'b1, 79, 101};
        vecs[3] = '{1'b0, 1'b0, 78, 100};
        vecs[4] = '{1'b1, 1'b1, 79, 101};

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ball_x", int'(ball_x), 78);
        check("rst_ball_y", int'(ball_y), 100);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        check("rst_plot", int'(vga_plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Vector table of frames starting from the reset position
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].xd, vecs[i].yd, 0);
            check("vec_ball_x", int'(ball_x), vecs[i].ex);
            check("vec_ball_y", int'(ball_y), vecs[i].ey);
        end

        // Right edge saturation
        for (int n = 0; n < 100 && mx < 156; n++) run_frame(1'b1, logic'(n % 2), 0);
        run_frame(1'b1, 1'b0, 0);
        run_frame(1'b1, 1'b1, 0);
        check("edge_x_sat", int'(ball_x), 156);

        // Origin saturation
        for (int n = 0; n < 200 && (mx > 0 || my > 0); n++) run_frame(1'b0, 1'b0, 0);
        run_frame(1'b0, 1'b0, 0);
        run_frame(1'b0, 1'b0, 0);
        check("origin_x", int'(ball_x), 0);
        check("origin_y", int'(ball_y), 0);

        // Tick while busy must be dropped
        run_frame(1'b1, 1'b1, 5);

        // Reset in the middle of DRAW
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_draw_busy", int'(busy), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("abort_plot", int'(vga_plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_ball_x", int'(ball_x), 78);
        check("abort_ball_y", int'(ball_y), 100);
        resetn = 1'b1;
        mx = 78; my = 100;
        @(posedge clk); #1;

        // Closed loop with a bouncing direction model
        xdir = 1; ydir = 0;
        for (int n = 0; n < 300; n++) begin
            if (mx >= 156) xdir = 0; else if (mx == 0) xdir = 1;
            if (my >= 116) ydir = 0; else if (my == 0) ydir = 1;
            run_frame(logic'(xdir), logic'(ydir), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
